mult_div_ctrl: RTL

- Multi-cycle controller for MIPS MULT/MULTU/DIV/DIVU. Owns the HI/LO register pair.
- Sequences a 32-iteration shift-add multiply or restoring divide over a shared 32-bit add/subtract datapath.
- The single-cycle core stalls on busy, then reads hi/lo for MFHI/MFLO.
- Also services MTHI/MTLO writes.

---
 rtl/mult_div_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_ctrl.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU controller that owns the HI/LO pair.
// Operands are converted to magnitudes on accept. One shared add/subtract
// datapath runs WIDTH iterations: shift-add for multiply, restoring division
// for divide. Signs are applied in a final fix-up cycle before HI/LO are written.
module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int AW = WIDTH + 2;  // datapath width: WIDTH+1 magnitude bits plus a borrow bit
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic                 is_div_r, sign_a_r, sign_b_r;
    logic [WIDTH-1:0]     mcand_r;      // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]   acc_r;        // {acc_hi, acc_lo}; for divide {remainder, quotient}
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 busy_r, done_r, dbz_r;

    logic                 accept_s, step_s, finish_s;
    logic [AW-1:0]        alu_a_s, alu_b_s, alu_y_s;
    logic                 alu_sub_s;
    logic [WIDTH:0]       shifted_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic                 dbz_s;
    logic [WIDTH-1:0]     hi_res_s, lo_res_s;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + ONE_W;
    endfunction

    // Magnitude of an operand: negated only when signed and negative.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !flush) state_s = S_RUN;
                else                 state_s = S_IDLE;
            end
            S_RUN: begin
                if (flush)                 state_s = S_IDLE;
                else if (cnt_r == CNT_LAST) state_s = S_FIX;
                else                       state_s = S_RUN;
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM control decodes driving the datapath and result registers.
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            S_IDLE:  accept_s = start && !flush;
            S_RUN:   step_s   = !flush;
            S_FIX:   finish_s = !flush;
            default: begin
                accept_s = 1'b0;
                step_s   = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Shared add/subtract datapath and one iteration of multiply or divide.
    always_comb begin
        shifted_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        if (is_div_r) begin
            alu_sub_s = 1'b1;
            alu_a_s   = {1'b0, shifted_s};
            alu_b_s   = {2'b00, mcand_r};
        end else begin
            alu_sub_s = 1'b0;
            alu_a_s   = {2'b00, acc_r[2*WIDTH-1:WIDTH]};
            if (acc_r[0]) alu_b_s = {2'b00, mcand_r};
            else          alu_b_s = {AW{1'b0}};
        end
        if (alu_sub_s) alu_y_s = alu_a_s - alu_b_s;
        else           alu_y_s = alu_a_s + alu_b_s;

        if (!is_div_r) begin
            acc_next_s = {alu_y_s[WIDTH:0], acc_r[WIDTH-1:1]};
        end else if (!alu_y_s[AW-1]) begin
            acc_next_s = {alu_y_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_next_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up. A zero divisor leaves the quotient as all ones; the remainder
    // still takes the dividend sign, which reproduces the raw dividend.
    always_comb begin
        dbz_s = is_div_r && (mcand_r == {WIDTH{1'b0}});
        if (sign_a_r ^ sign_b_r) prod_s = (~acc_r) + ONE_2W;
        else                     prod_s = acc_r;
        if (is_div_r) begin
            if (sign_a_r) hi_res_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
            else          hi_res_s = acc_r[2*WIDTH-1:WIDTH];
            if ((sign_a_r ^ sign_b_r) && !dbz_s) lo_res_s = neg_w(acc_r[WIDTH-1:0]);
            else                                 lo_res_s = acc_r[WIDTH-1:0];
        end else begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
    end

    // Operand capture on accept and iteration state while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_r <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            mcand_r  <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            is_div_r <= op[1];
            sign_a_r <= op[0] && inpA[WIDTH-1];
            sign_b_r <= op[0] && inpB[WIDTH-1];
            cnt_r    <= {CNT_W{1'b0}};
            if (op[1]) begin
                mcand_r <= mag_w(inpB, op[0]);
                acc_r   <= {{WIDTH{1'b0}}, mag_w(inpA, op[0])};
            end else begin
                mcand_r <= mag_w(inpA, op[0]);
                acc_r   <= {{WIDTH{1'b0}}, mag_w(inpB, op[0])};
            end
        end else if (step_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= (state_r == S_RUN) ? cnt_r : {CNT_W{1'b0}};
        end
    end

    // HI/LO, status outputs; MTHI/MTLO only land while not busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= finish_s;
            if (finish_s) begin
                hi_r  <= hi_res_s;
                lo_r  <= lo_res_s;
                dbz_r <= dbz_s;
            end else begin
                if (hi_we && !busy_r) hi_r <= wdata;
                if (lo_we && !busy_r) lo_r <= wdata;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
